// File: rtl/freq_accum_write_pkg.sv
// Shared types and helpers for the frequency-domain accumulate/drain block.
// Contents: data widths, bank depth, complex word types, FSM state enum,
// and sign-extend / complex-add helpers.
package freq_accum_write_pkg;

    localparam int unsigned DATALEN = 16;
    localparam int unsigned ACCLEN  = 24;
    localparam int unsigned INDXLEN = 6;
    localparam int unsigned CHNLEN  = 10;
    localparam int unsigned NIDX    = 1 << INDXLEN;

    // Input product: real in upper half, imag in lower half
    typedef struct packed {
        logic signed [DATALEN-1:0] re;
        logic signed [DATALEN-1:0] im;
    } in_cplx_t;

    // Accumulator word: real in upper half, imag in lower half
    typedef struct packed {
        logic signed [ACCLEN-1:0] re;
        logic signed [ACCLEN-1:0] im;
    } acc_cplx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic signed [ACCLEN-1:0] sext(input logic signed [DATALEN-1:0] v);
        return {{(ACCLEN-DATALEN){v[DATALEN-1]}}, v};
    endfunction

    // Component-wise add, wrapping modulo 2**ACCLEN
    function automatic acc_cplx_t cplx_add(input acc_cplx_t a, input in_cplx_t b);
        acc_cplx_t r;
        r.re = a.re + sext(b.re);
        r.im = a.im + sext(b.im);
        return r;
    endfunction

endpackage

// File: rtl/freq_accum_write_if.sv
// Product-in and drain-out bus of freq_accum_write.
// Upstream side: indata/inindex/invalid/chanend. Drain side: out_data,
// out_index, out_valid (toward consumer) and out_ready (from consumer).
// master = upstream producer + drain consumer, slave = the accumulator.
interface freq_accum_write_if
    import freq_accum_write_pkg::*;
#(
    parameter int unsigned PARAKRN = 64,
    parameter int unsigned PARATIL = 9
) ();

    in_cplx_t  [PARATIL-1:0][PARAKRN-1:0] indata;
    logic      [PARAKRN-1:0][INDXLEN-1:0] inindex;
    logic      [PARAKRN-1:0]              invalid;
    logic                                 chanend;

    acc_cplx_t [PARATIL-1:0][PARAKRN-1:0] out_data;
    logic      [INDXLEN-1:0]              out_index;
    logic                                 out_valid;
    logic                                 out_ready;

    modport master (
        output indata, inindex, invalid, chanend, out_ready,
        input  out_data, out_index, out_valid
    );

    modport slave (
        input  indata, inindex, invalid, chanend, out_ready,
        output out_data, out_index, out_valid
    );

endinterface

// File: rtl/freq_accum_lane.sv
// One kernel lane's accumulator bank: PARATIL tiles x NIDX complex entries.
// Ports: clk, rst (async active-high), clr (zero whole bank), acc_en +
// wr_idx + wr_data (add one product per tile at wr_idx), rd_idx ->
// rd_data_c (combinational read of all tiles at rd_idx).
module freq_accum_lane
    import freq_accum_write_pkg::*;
#(
    parameter int unsigned PARATIL = 9
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      acc_en,
    input  logic [INDXLEN-1:0]        wr_idx,
    input  in_cplx_t  [PARATIL-1:0]   wr_data,
    input  logic [INDXLEN-1:0]        rd_idx,
    output acc_cplx_t [PARATIL-1:0]   rd_data_c
);

    acc_cplx_t bank_q [PARATIL][NIDX];
    acc_cplx_t bank_d [PARATIL][NIDX];

    // Single-cycle read-modify-write: back-to-back hits on one index chain
    // through bank_q without a stall.
    always_comb begin
        bank_d = bank_q;
        if (clr) begin
            for (int unsigned t = 0; t < PARATIL; t++) begin
                for (int unsigned i = 0; i < NIDX; i++) begin
                    bank_d[t][i] = '0;
                end
            end
        end else if (acc_en) begin
            for (int unsigned t = 0; t < PARATIL; t++) begin
                bank_d[t][wr_idx] = cplx_add(bank_q[t][wr_idx], wr_data[t]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned t = 0; t < PARATIL; t++) begin
                for (int unsigned i = 0; i < NIDX; i++) begin
                    bank_q[t][i] <= '0;
                end
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < PARATIL; t++) begin
            rd_data_c[t] = bank_q[t][rd_idx];
        end
    end

endmodule

// File: rtl/freq_accum_write.sv
// Accumulates complex frequency-domain products across channel passes into
// a per-lane, per-tile, per-index bank, then drains it one index per
// handshake.
// Ports: clk, rst (async active-high), start (job pulse), nchan (passes per
// job, 0 means 1), busy (ACCUM or DRAIN), done (pulse after last drain
// beat), bus (slave side of freq_accum_write_if).
module freq_accum_write
    import freq_accum_write_pkg::*;
#(
    parameter int unsigned PARAKRN = 64,
    parameter int unsigned PARATIL = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CHNLEN-1:0]  nchan,
    output logic               busy,
    output logic               done,
    freq_accum_write_if.slave  bus
);

    state_e                                state_q, state_d;
    logic      [CHNLEN-1:0]                nchan_q, nchan_d;
    logic      [CHNLEN-1:0]                chan_cnt_q, chan_cnt_d;
    logic      [INDXLEN-1:0]               out_index_q, out_index_d;
    logic                                  out_valid_q, out_valid_d;
    acc_cplx_t [PARATIL-1:0][PARAKRN-1:0]  out_data_q, out_data_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;

    logic                                  clr_c;
    logic      [INDXLEN-1:0]               rd_idx_c;
    logic      [PARAKRN-1:0]               acc_en_c;
    in_cplx_t  [PARAKRN-1:0][PARATIL-1:0]  lane_wr_c;
    acc_cplx_t [PARAKRN-1:0][PARATIL-1:0]  lane_rd_c;
    acc_cplx_t [PARATIL-1:0][PARAKRN-1:0]  rd_data_c;

    // Regroup tile-major bus data to lane-major for the lane banks and back
    always_comb begin
        for (int unsigned k = 0; k < PARAKRN; k++) begin
            acc_en_c[k] = (state_q == ST_ACCUM) && bus.invalid[k];
            for (int unsigned t = 0; t < PARATIL; t++) begin
                lane_wr_c[k][t] = bus.indata[t][k];
                rd_data_c[t][k] = lane_rd_c[k][t];
            end
        end
    end

    for (genvar k = 0; k < PARAKRN; k++) begin : g_lane
        freq_accum_lane #(.PARATIL(PARATIL)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr_c),
            .acc_en    (acc_en_c[k]),
            .wr_idx    (bus.inindex[k]),
            .wr_data   (lane_wr_c[k]),
            .rd_idx    (rd_idx_c),
            .rd_data_c (lane_rd_c[k])
        );
    end

    // Next state, channel counting and drain sequencing
    always_comb begin
        state_d     = state_q;
        nchan_d     = nchan_q;
        chan_cnt_d  = chan_cnt_q;
        out_index_d = out_index_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        clr_c       = 1'b0;
        // Drain read pointer: index 0 on entry, otherwise the next index
        rd_idx_c    = out_valid_q ? out_index_q + INDXLEN'(1) : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr_c      = 1'b1;
                    nchan_d    = (nchan == '0) ? CHNLEN'(1) : nchan;
                    chan_cnt_d = '0;
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.chanend) begin
                    if (chan_cnt_q == nchan_q - CHNLEN'(1)) begin
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b0;
                    end else begin
                        chan_cnt_d = chan_cnt_q + CHNLEN'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_index_d = rd_idx_c;
                    out_data_d  = rd_data_c;
                end else if (bus.out_ready) begin
                    if (out_index_q == INDXLEN'(NIDX - 1)) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        out_index_d = rd_idx_c;
                        out_data_d  = rd_data_c;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            nchan_q     <= '0;
            chan_cnt_q  <= '0;
            out_index_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            nchan_q     <= nchan_d;
            chan_cnt_q  <= chan_cnt_d;
            out_index_q <= out_index_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_freq_accum_write.sv
// Self-checking bench for freq_accum_write with a reduced lane/tile count.
// A per-entry sum model is updated by the stimulus tasks; one compare
// process checks every drain beat and the done pulse against it.
module tb_freq_accum_write;
    import freq_accum_write_pkg::*;

    localparam int unsigned PK = 4;
    localparam int unsigned PT = 2;
    localparam int PH_IDLE  = 0;
    localparam int PH_ACCUM = 1;
    localparam int PH_DRAIN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CHNLEN-1:0] nchan;
    logic              busy;
    logic              done;

    freq_accum_write_if #(.PARAKRN(PK), .PARATIL(PT)) bus ();

    freq_accum_write #(.PARAKRN(PK), .PARATIL(PT)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .nchan (nchan),
        .busy  (busy),
        .done  (done),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int phase = PH_IDLE;
    int m_re [PT][PK][NIDX];
    int m_im [PT][PK][NIDX];
    logic [ACCLEN-1:0] cap_re [PT][PK][NIDX];
    logic [ACCLEN-1:0] cap_im [PT][PK][NIDX];
    int m_nchan;
    int m_pass;
    int exp_idx = 0;
    bit exp_done = 1'b0;
    int hs_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.indata  = '0;
        bus.inindex = '0;
        bus.invalid = '0;
        bus.chanend = 1'b0;
        start       = 1'b0;
    endtask

    task automatic start_job(input int n);
        nchan = CHNLEN'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < PT; t++)
            for (int k = 0; k < PK; k++)
                for (int i = 0; i < NIDX; i++) begin
                    m_re[t][k][i] = 0;
                    m_im[t][k][i] = 0;
                end
        m_nchan = (n == 0) ? 1 : n;
        m_pass  = 0;
        phase   = PH_ACCUM;
    endtask

    // One input cycle: optional product on lane k / tile t, optional chanend
    task automatic beat(input bit vld, input int k, input int idx, input int t,
                        input int re, input int im, input bit ce);
        clear_in();
        if (vld) begin
            bus.indata[t][k]  = {DATALEN'(re), DATALEN'(im)};
            bus.invalid[k]    = 1'b1;
            bus.inindex[k]    = INDXLEN'(idx);
        end
        bus.chanend = ce;
        tick();
        if (phase == PH_ACCUM) begin
            if (vld) begin
                m_re[t][k][idx] += re;
                m_im[t][k][idx] += im;
            end
            if (ce) begin
                m_pass++;
                if (m_pass == m_nchan) begin
                    phase   = PH_DRAIN;
                    exp_idx = 0;
                    hs_cnt  = 0;
                end
            end
        end
        clear_in();
    endtask

    // Called in the cycle after the final chanend; optional stall and
    // injection of ignored inputs (valid beats, chanend, start) while draining.
    task automatic run_drain(input int stall_at, input int stall_len, input bit inject);
        int stalls = 0;
        bit got = 1'b0;
        chk("lat_first_cycle_valid", bus.out_valid, 1'b0);
        chk("busy_entering_drain", busy, 1'b1);
        tick();
        chk("lat_second_cycle_valid", bus.out_valid, 1'b1);
        chk("lat_second_cycle_index", bus.out_index, 0);
        for (int cyc = 0; cyc < 4 * NIDX; cyc++) begin
            if (bus.out_valid && int'(bus.out_index) == stall_at && stalls < stall_len) begin
                bus.out_ready = 1'b0;
                stalls++;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (inject && cyc < 8) begin
                bus.invalid = '1;
                bus.chanend = 1'b1;
                for (int t = 0; t < PT; t++)
                    for (int k = 0; k < PK; k++) begin
                        bus.indata[t][k] = {DATALEN'(7), DATALEN'(7)};
                        bus.inindex[k]   = INDXLEN'(20);
                    end
                start = (cyc == 3);
            end else begin
                clear_in();
            end
            tick();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        clear_in();
        bus.out_ready = 1'b1;
        chk("done_seen", got, 1'b1);
        chk("handshake_count", hs_cnt, NIDX);
        chk("busy_at_done", busy, 1'b0);
        phase = PH_IDLE;
    endtask

    // Compare process: every cycle checks done, and every valid drain beat
    // against the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_idx  = 0;
            exp_done = 1'b0;
        end else begin
            chk("done", done, exp_done);
            exp_done = 1'b0;
            if (phase != PH_DRAIN) begin
                chk("valid_outside_drain", bus.out_valid, 1'b0);
            end else if (bus.out_valid) begin
                chk("out_index", bus.out_index, exp_idx);
                for (int t = 0; t < PT; t++)
                    for (int k = 0; k < PK; k++)
                        chk($sformatf("data t%0d k%0d i%0d", t, k, exp_idx),
                            bus.out_data[t][k],
                            {ACCLEN'(m_re[t][k][exp_idx]), ACCLEN'(m_im[t][k][exp_idx])});
                if (bus.out_ready) begin
                    for (int t = 0; t < PT; t++)
                        for (int k = 0; k < PK; k++) begin
                            cap_re[t][k][exp_idx] = bus.out_data[t][k].re;
                            cap_im[t][k][exp_idx] = bus.out_data[t][k].im;
                        end
                    hs_cnt++;
                    if (exp_idx == NIDX - 1) begin
                        exp_done = 1'b1;
                        exp_idx  = 0;
                    end else begin
                        exp_idx++;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_in();
        nchan = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_index", bus.out_index, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_data_t0k0", bus.out_data[0][0], 48'h0);
        rst = 1'b0;
        tick();

        // Single channel: lane0 idx3 tile0 = 5 - 2j
        start_job(1);
        chk("busy_after_start", busy, 1'b1);
        beat(1'b1, 0, 3, 0, 5, -2, 1'b0);
        beat(1'b0, 0, 0, 0, 0, 0, 1'b1);
        run_drain(-1, 0, 1'b0);
        chk("t1_re", cap_re[0][0][3], 24'h000005);
        chk("t1_im", cap_im[0][0][3], 24'hFFFFFE);
        chk("t1_unwritten", cap_re[0][0][2], 24'h000000);
        tick();

        // Same index back-to-back: +100 then -30
        start_job(1);
        beat(1'b1, 1, 7, 0, 100, 0, 1'b0);
        beat(1'b1, 1, 7, 0, -30, 0, 1'b1);
        run_drain(-1, 0, 1'b0);
        chk("t2_re", cap_re[0][1][7], 24'd70);
        tick();

        // Three passes of +1000; drain only after the third chanend
        start_job(3);
        beat(1'b1, 2, 5, 1, 0, -7, 1'b0);
        for (int p = 0; p < 3; p++) begin
            beat(1'b1, 2, 0, 0, 1000, 0, 1'b1);
            if (p < 2) chk("t3_busy_between_passes", busy, 1'b1);
        end
        run_drain(-1, 0, 1'b0);
        chk("t3_re", cap_re[0][2][0], 24'd3000);
        chk("t3_tile1_im", cap_im[1][2][5], 24'hFFFFF9);
        tick();

        // Backpressure at index 10, with ignored inputs and start while draining
        start_job(1);
        beat(1'b1, 0, 10, 1, -1234, 999, 1'b0);
        beat(1'b1, 3, 11, 1, 50, 50, 1'b1);
        run_drain(10, 5, 1'b1);
        chk("t4_re", cap_re[1][0][10], 24'hFFFB2E);
        chk("t4_im", cap_im[1][0][10], 24'd999);
        chk("t4_inject_ignored", cap_re[0][0][20], 24'h000000);
        tick();
        tick();
        chk("t4_start_in_drain_ignored", busy, 1'b0);

        // Extremes: 256 x -32768 reaches -2**23 exactly; one more wraps
        start_job(1);
        for (int i = 0; i < 256; i++) beat(1'b1, 3, 63, 1, -32768, 1, i == 255);
        run_drain(-1, 0, 1'b0);
        chk("t5_min_re", cap_re[1][3][63], 24'h800000);
        chk("t5_min_im", cap_im[1][3][63], 24'h000100);
        tick();
        start_job(1);
        for (int i = 0; i < 257; i++) beat(1'b1, 3, 63, 1, -32768, 1, i == 256);
        run_drain(-1, 0, 1'b0);
        chk("t5_wrap_re", cap_re[1][3][63], 24'h7F8000);
        chk("t5_wrap_im", cap_im[1][3][63], 24'h000101);
        tick();

        // Reset mid-ACCUM clears outputs (out_data still holds the last beat)
        start_job(2);
        beat(1'b1, 0, 4, 0, 11, 0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        phase = PH_IDLE;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_out_index", bus.out_index, 0);
        for (int t = 0; t < PT; t++)
            for (int k = 0; k < PK; k++)
                chk($sformatf("mid_rst_data t%0d k%0d", t, k), bus.out_data[t][k], 48'h0);
        tick();
        tick();
        rst = 1'b0;

        // Beats and chanend in IDLE do nothing
        beat(1'b1, 0, 4, 0, 99, 0, 1'b1);
        beat(1'b1, 1, 4, 0, 99, 0, 1'b1);
        chk("idle_ignores_inputs", busy, 1'b0);
        tick();

        // nchan=0 behaves as a single pass
        start_job(0);
        beat(1'b1, 1, 9, 1, -5, 5, 1'b1);
        run_drain(-1, 0, 1'b0);
        chk("t7_re", cap_re[1][1][9], 24'hFFFFFB);
        chk("t7_im", cap_im[1][1][9], 24'h000005);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
